// File: rtl/cp0_timer.sv
// CP0 coprocessor block: status/cause/EPC bookkeeping, exception and interrupt
// request generation, and an optional Count/Compare timer.
module cp0_timer #(
   parameter int unsigned NUM_HWINT = 6,
   parameter bit          TIMER_EN  = 1'b1,
   parameter logic [31:0] PRID_VAL  = 32'h1837_3580
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           A1,
   input  logic [4:0]           A2,
   input  logic [31:0]          DIn,
   input  logic                 We,
   input  logic [31:0]          PC,
   input  logic [6:2]           ExcCode,
   input  logic [31:0]          BadAddr,
   input  logic [NUM_HWINT-1:0] HWInt,
   input  logic                 delayslot,
   input  logic                 EXLClr,
   output logic                 IntReq,
   output logic [31:0]          EPC,
   output logic [31:0]          DOut
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_SR       = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   // Status register fields
   logic                 exl_q;
   logic                 ie_q;
   logic                 tie_q;
   logic [NUM_HWINT-1:0] im_q;

   // Cause register fields
   logic                 bd_q;
   logic [4:0]           exc_code_q;
   logic [NUM_HWINT-1:0] ip_q;

   logic [31:0]          epc_q;
   logic [31:0]          badvaddr_q;

   // Timer state
   logic [31:0]          count_q;
   logic [31:0]          compare_q;
   logic                 ti_q;

   logic                 pending;
   logic                 interrupt;
   logic                 take;
   logic                 mtc0;
   logic [31:0]          epc_base;
   logic [31:0]          epc_exc;
   logic [5:0]           im_w;
   logic [5:0]           ip_w;
   logic [31:0]          sr_w;
   logic [31:0]          cause_w;
   logic                 unused_pc_bits;

   assign unused_pc_bits = ^PC[1:0];

   // Interrupt / exception request; a taken request blocks any MTC0 that cycle
   assign pending   = (|(HWInt & im_q)) | (ti_q & tie_q);
   assign interrupt = pending & ie_q & ~exl_q;
   assign take      = ~exl_q & (interrupt | (ExcCode != 5'd0));
   assign mtc0      = We & ~take;
   assign IntReq    = take & ~reset;

   // Restart address: word-aligned PC, backed up to the branch for delay slots
   assign epc_base = {PC[31:2], 2'b00};
   assign epc_exc  = delayslot ? (epc_base - 32'd4) : epc_base;

   assign im_w    = 6'(im_q);
   assign ip_w    = 6'(ip_q);
   assign sr_w    = {15'b0, tie_q, im_w, 8'b0, exl_q, ie_q};
   assign cause_w = {bd_q, ti_q, 14'b0, ip_w, 3'b0, exc_code_q, 2'b00};
   assign EPC     = epc_q;

   // Status register: exception sets EXL, ERET clears it, MTC0 loads fields
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         tie_q <= 1'b0;
         im_q  <= '0;
      end else if (take) begin
         exl_q <= 1'b1;
      end else begin
         if (mtc0 && (A2 == REG_SR)) begin
            tie_q <= DIn[16];
            im_q  <= DIn[10 +: NUM_HWINT];
            exl_q <= DIn[1];
            ie_q  <= DIn[0];
         end
         if (EXLClr) begin
            exl_q <= 1'b0;
         end
      end
   end

   // Cause register: IP tracks the lines every cycle, BD/ExcCode latch on a taken request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ip_q       <= '0;
         bd_q       <= 1'b0;
         exc_code_q <= 5'd0;
      end else begin
         ip_q <= HWInt;
         if (take) begin
            bd_q       <= delayslot;
            exc_code_q <= interrupt ? 5'd0 : ExcCode;
         end
      end
   end

   // EPC: captured on a taken request, otherwise writable by MTC0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         epc_q <= 32'd0;
      end else if (take) begin
         epc_q <= epc_exc;
      end else if (mtc0 && (A2 == REG_EPC)) begin
         epc_q <= {DIn[31:2], 2'b00};
      end
   end

   // BadVAddr: captured only for address-error exceptions (AdEL/AdES)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         badvaddr_q <= 32'd0;
      end else if (take && !interrupt && ((ExcCode == 5'd4) || (ExcCode == 5'd5))) begin
         badvaddr_q <= BadAddr;
      end
   end

   // Count/Compare timer with sticky TI; a Compare write always clears TI
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         ti_q      <= 1'b0;
      end else if (!TIMER_EN) begin
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         ti_q      <= 1'b0;
      end else begin
         count_q <= (mtc0 && (A2 == REG_COUNT)) ? DIn : (count_q + 32'd1);
         if (mtc0 && (A2 == REG_COMPARE)) begin
            compare_q <= DIn;
            ti_q      <= 1'b0;
         end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            ti_q <= 1'b1;
         end
      end
   end

   // MFC0 read mux; returns pre-edge values, no write bypass
   always_comb begin
      DOut = 32'd0;
      case (A1)
         REG_BADVADDR: DOut = badvaddr_q;
         REG_COUNT:    DOut = count_q;
         REG_COMPARE:  DOut = compare_q;
         REG_SR:       DOut = sr_w;
         REG_CAUSE:    DOut = cause_w;
         REG_EPC:      DOut = epc_q;
         REG_PRID:     DOut = PRID_VAL;
         default:      DOut = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_timer.sv
// Bench for cp0_timer: directed scenarios plus randomized traffic against a
// word-level model of the CP0 registers.
module tb_cp0_timer;

   localparam logic [31:0] PRID = 32'h1837_3580;

   logic        clk;
   logic        reset;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [31:0] din;
   logic        we;
   logic [31:0] pc;
   logic [4:0]  exc_code;
   logic [31:0] bad_addr;
   logic [5:0]  hw_int;
   logic        delayslot;
   logic        exl_clr;
   logic        int_req;
   logic [31:0] epc;
   logic [31:0] dout;

   int vectors = 0;
   int errors  = 0;

   // Model state kept as whole architectural words
   logic [31:0] m_sr, m_cause, m_epc, m_bad, m_cnt, m_cmp;

   cp0_timer dut (
      .clk       (clk),
      .reset     (reset),
      .A1        (a1),
      .A2        (a2),
      .DIn       (din),
      .We        (we),
      .PC        (pc),
      .ExcCode   (exc_code),
      .BadAddr   (bad_addr),
      .HWInt     (hw_int),
      .delayslot (delayslot),
      .EXLClr    (exl_clr),
      .IntReq    (int_req),
      .EPC       (epc),
      .DOut      (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic m_intr();
      logic hw_pend;
      hw_pend = (({16'b0, hw_int, 10'b0} & m_sr & 32'h0000_FC00) != 32'd0);
      return (hw_pend || (m_cause[30] && m_sr[16])) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_req();
      return !m_sr[1] && (m_intr() || (exc_code != 5'd0));
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      case (r)
         5'd8:    return m_bad;
         5'd9:    return m_cnt;
         5'd11:   return m_cmp;
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_clear();
      m_sr = 0; m_cause = 0; m_epc = 0; m_bad = 0; m_cnt = 0; m_cmp = 0;
   endtask

   // Advance one clock, computing the model's next state from the held inputs
   task automatic tick();
      logic [31:0] n_sr, n_cause, n_epc, n_bad, n_cnt, n_cmp;
      logic intr, req;
      intr = m_intr();
      req  = m_req();
      n_sr = m_sr; n_cause = m_cause; n_epc = m_epc; n_bad = m_bad;
      n_cnt = m_cnt + 32'd1; n_cmp = m_cmp;
      if (m_cnt == m_cmp && m_cmp != 0) n_cause[30] = 1'b1;
      n_cause[15:10] = hw_int;
      if (req) begin
         n_sr[1] = 1'b1;
         n_cause[31] = delayslot;
         n_cause[6:2] = intr ? 5'd0 : exc_code;
         n_epc = (pc & ~32'd3) - (delayslot ? 32'd4 : 32'd0);
         if (!intr && (exc_code == 5'd4 || exc_code == 5'd5)) n_bad = bad_addr;
      end else begin
         if (we) begin
            case (a2)
               5'd9:  n_cnt = din;
               5'd11: begin n_cmp = din; n_cause[30] = 1'b0; end
               5'd12: n_sr = din & 32'h0001_FC03;
               5'd14: n_epc = din & ~32'd3;
               default: ;
            endcase
         end
         if (exl_clr) n_sr[1] = 1'b0;
      end
      @(posedge clk);
      m_sr = n_sr; m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
      m_cnt = n_cnt; m_cmp = n_cmp;
      #1;
   endtask

   task automatic idle_inputs();
      a1 = 5'd0; a2 = 5'd0; din = 0; we = 0; pc = 0; exc_code = 0;
      bad_addr = 0; hw_int = 0; delayslot = 0; exl_clr = 0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      m_clear();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] regs [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
      reset = 1'b1;
      idle_inputs();
      exc_code = 5'd6;
      m_clear();
      #3;
      vectors++;
      if (int_req !== 1'b0) begin
         errors++; $display("FAIL reset_intreq: got %b expected 0", int_req);
      end
      exc_code = 5'd0;
      for (int i = 0; i < 7; i++) begin
         a1 = regs[i];
         #1;
         vectors++;
         if (dout !== ((regs[i] == 5'd15) ? PRID : 32'd0)) begin
            errors++; $display("FAIL reset_read r%0d: got %h expected %h", regs[i], dout,
                               (regs[i] == 5'd15) ? PRID : 32'd0);
         end
      end
      reset_dut();
   endtask

   task automatic test_hw_interrupt();
      reset_dut();
      we = 1; a2 = 5'd12; din = 32'h0000_0401;
      tick();
      we = 0; hw_int = 6'b000001; pc = 32'h3000; delayslot = 0;
      #1;
      vectors++;
      if (int_req !== 1'b1) begin
         errors++; $display("FAIL hwint_req: got %b expected 1", int_req);
      end
      tick();
      a1 = 5'd13; #1;
      vectors++;
      if (epc !== 32'h3000 || dout !== 32'h0000_0400) begin
         errors++; $display("FAIL hwint_taken: epc %h cause %h expected 3000 00000400", epc, dout);
      end
      a1 = 5'd12; #1;
      vectors++;
      if (dout[1] !== 1'b1 || int_req !== 1'b0) begin
         errors++; $display("FAIL hwint_exl: exl %b intreq %b expected 1 0", dout[1], int_req);
      end
      hw_int = 0;
   endtask

   task automatic test_address_error();
      reset_dut();
      exc_code = 5'd4; bad_addr = 32'h1235; pc = 32'h3008; delayslot = 1;
      #1;
      vectors++;
      if (int_req !== 1'b1) begin
         errors++; $display("FAIL adel_req: got %b expected 1", int_req);
      end
      tick();
      exc_code = 0; delayslot = 0;
      a1 = 5'd13; #1;
      vectors++;
      if (epc !== 32'h3004 || dout !== 32'h8000_0010) begin
         errors++; $display("FAIL adel_cause: epc %h cause %h expected 3004 80000010", epc, dout);
      end
      a1 = 5'd8; #1;
      vectors++;
      if (dout !== 32'h1235) begin
         errors++; $display("FAIL adel_badvaddr: got %h expected 00001235", dout);
      end
   endtask

   task automatic test_timer();
      bit hit;
      reset_dut();
      we = 1; a2 = 5'd12; din = 32'h0001_0001;
      tick();
      a2 = 5'd11; din = 32'd10;
      tick();
      we = 0; a1 = 5'd9;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         #1;
         if (dout == 32'd10) hit = 1;
         else tick();
      end
      vectors++;
      if (!hit) begin
         errors++; $display("FAIL timer_reach: count %h never reached 0000000a", dout);
      end
      a1 = 5'd13; #1;
      vectors++;
      if (dout[30] !== 1'b0) begin
         errors++; $display("FAIL timer_ti_early: got %b expected 0", dout[30]);
      end
      tick();
      #1;
      vectors++;
      if (dout[30] !== 1'b1 || int_req !== 1'b1) begin
         errors++; $display("FAIL timer_ti_set: ti %b intreq %b expected 1 1", dout[30], int_req);
      end
      tick();
      #1;
      vectors++;
      if (dout[6:2] !== 5'd0 || m_sr[1] !== 1'b1 || int_req !== 1'b0) begin
         errors++; $display("FAIL timer_taken: exccode %0d intreq %b expected 0 0", dout[6:2], int_req);
      end
      we = 1; a2 = 5'd11; din = 32'd0;
      tick();
      we = 0; #1;
      vectors++;
      if (dout[30] !== 1'b0) begin
         errors++; $display("FAIL timer_ti_clear: got %b expected 0", dout[30]);
      end
   endtask

   task automatic test_count_wrap();
      logic [31:0] want [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
      reset_dut();
      we = 1; a2 = 5'd9; din = 32'hFFFF_FFFE;
      tick();
      we = 0; a1 = 5'd9;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if (dout !== want[i] || dout !== m_cnt) begin
            errors++; $display("FAIL count_wrap[%0d]: got %h expected %h", i, dout, want[i]);
         end
         tick();
      end
   endtask

   task automatic test_write_vs_exception();
      reset_dut();
      we = 1; a2 = 5'd14; din = 32'h4000; exc_code = 5'd10; pc = 32'h3010;
      #1;
      vectors++;
      if (int_req !== 1'b1) begin
         errors++; $display("FAIL wvse_req: got %b expected 1", int_req);
      end
      tick();
      we = 0; exc_code = 0; exl_clr = 1;
      #1;
      vectors++;
      if (epc !== 32'h3010) begin
         errors++; $display("FAIL wvse_epc: got %h expected 00003010", epc);
      end
      tick();
      exl_clr = 0; a1 = 5'd12; #1;
      vectors++;
      if (dout[1] !== 1'b0) begin
         errors++; $display("FAIL wvse_exlclr: exl %b expected 0", dout[1]);
      end
   endtask

   task automatic test_async_reset();
      logic [4:0] regs [4] = '{5'd12, 5'd13, 5'd14, 5'd15};
      exc_code = 5'd6; pc = 32'h5000;
      tick();
      #2;
      vectors++;
      if (m_sr[1] !== 1'b1 || dout[1] !== 1'b1) begin
         errors++; $display("FAIL areset_pre: exl %b expected 1", dout[1]);
      end
      reset = 1'b1;
      m_clear();
      for (int i = 0; i < 4; i++) begin
         a1 = regs[i];
         #1;
         vectors++;
         if (dout !== m_read(regs[i]) || epc !== 32'd0 || int_req !== 1'b0) begin
            errors++; $display("FAIL areset_r%0d: dout %h epc %h intreq %b expected %h 0 0",
                               regs[i], dout, epc, int_req, m_read(regs[i]));
         end
      end
      reset_dut();
   endtask

   task automatic test_random();
      logic [4:0] regs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
      reset_dut();
      for (int n = 0; n < 400; n++) begin
         a1 = regs[$urandom_range(0, 7)];
         a2 = regs[$urandom_range(0, 7)];
         we = ($urandom_range(0, 2) == 0);
         din = $urandom;
         if (a2 == 5'd11 && $urandom_range(0, 1) == 0) din = m_cnt + 32'($urandom_range(1, 6));
         if (a2 == 5'd12 && $urandom_range(0, 1) == 0) din = din | 32'h1;
         pc = $urandom;
         bad_addr = $urandom;
         delayslot = $urandom_range(0, 1);
         exl_clr = ($urandom_range(0, 5) == 0);
         hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         case ($urandom_range(0, 9))
            0: exc_code = 5'd4;
            1: exc_code = 5'd5;
            2: exc_code = 5'($urandom_range(1, 31));
            default: exc_code = 5'd0;
         endcase
         #1;
         vectors++;
         if (int_req !== m_req() || dout !== m_read(a1) || epc !== m_epc) begin
            errors++;
            $display("FAIL random[%0d]: intreq %b dout(r%0d) %h epc %h expected %b %h %h",
                     n, int_req, a1, dout, epc, m_req(), m_read(a1), m_epc);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_hw_interrupt();
      test_address_error();
      test_timer();
      test_count_wrap();
      test_write_vs_exception();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/cp0_timer.md
CP0_TIMER -- requirements
Module: cp0_timer

Interface
REQ-001 Parameter NUM_HWINT, default 6, number of external interrupt lines (legal 1..6), mapped to SR.IM/Cause.IP bits [10 +: NUM_HWINT].
REQ-002 Parameter TIMER_EN, default 1, includes the Count/Compare timer; when 0, Count, Compare and TI read 0 and never change.
REQ-003 Parameter PRID_VAL, default 32'h18373580, read-only PRId value.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears state immediately on assertion, independent of clk.
REQ-006 A1  input  5  read register number (MFC0).
REQ-007 A2  input  5  write register number (MTC0).
REQ-008 DIn  input  32  write data.
REQ-009 We  input  1  write enable (MTC0 in M stage).
REQ-010 PC  input  32  PC of the M-stage instruction.
REQ-011 ExcCode  input  5  [6:2] exception code of the M-stage instruction; 0 = none.
REQ-012 BadAddr  input  32  faulting data/instruction address.
REQ-013 HWInt  input  NUM_HWINT  level-sensitive external interrupt lines.
REQ-014 delayslot  input  1  M-stage instruction is in a branch delay slot.
REQ-015 EXLClr  input  1  ERET commits; clears SR.EXL.
REQ-016 IntReq  output  1  take exception/interrupt this cycle (combinational).
REQ-017 EPC  output  32  current EPC register.
REQ-018 DOut  output  32  read data selected by A1 (combinational).

Function
REQ-019 Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId; any other A1 reads 0.
REQ-020 SR = {15'b0, TIE[16], IM[15:10], 8'b0, EXL[1], IE[0]}; unimplemented IM bits read 0.
REQ-021 Cause = {BD[31], TI[30], 14'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}.
REQ-022 Cause.IP copies HWInt every cycle, regardless of EXL.
REQ-023 Pending interrupt = (|(HWInt & IM)) | (TI & TIE); interrupt = pending & IE & !EXL.
REQ-024 IntReq = !EXL & (interrupt | ExcCode != 0).
REQ-025 Interrupt has priority over exception: if interrupt=1, recorded ExcCode is 0, else the ExcCode input.
REQ-026 On an edge with IntReq=1: EXL<=1; BD<=delayslot; EPC<={PC[31:2],2'b0} minus 4 if delayslot, else {PC[31:2],2'b0}; Cause.ExcCode is updated.
REQ-027 BadVAddr<=BadAddr only when a non-interrupt exception with ExcCode 4 (AdEL) or 5 (AdES) is taken; otherwise BadVAddr holds.
REQ-028 Cause.BD, Cause.ExcCode, EPC and BadVAddr change only on a taken IntReq or a legal MTC0; they hold while EXL=1.
REQ-029 MTC0 (We=1, IntReq=0): SR writes TIE/IM/EXL/IE from DIn; EPC<={DIn[31:2],2'b0}; Count<=DIn; Compare<=DIn and TI<=0; writes to Cause, PRId, BadVAddr and unmapped numbers are ignored.
REQ-030 We=1 and IntReq=1 in the same cycle: the exception wins and the write is discarded.
REQ-031 EXLClr=1 with IntReq=0: EXL<=0; with IntReq=1 (EXL was 0), EXL ends 1.
REQ-032 Count increments by 1 each cycle, mod 2^32 (FFFFFFFF wraps to 0); an MTC0 to Count replaces the increment that cycle.
REQ-033 TI<=1 on an edge where Count==Compare and Compare!=0; TI is sticky until an MTC0 to Compare or reset.
REQ-034 A simultaneous TI set condition and Compare write leave TI=0.
REQ-035 A read of a register being written in the same cycle returns the old value; there is no internal bypass.

Reset
REQ-036 On reset, SR, Cause, EPC, BadVAddr, Count, Compare and TI clear to 0; PRId reads PRID_VAL.
REQ-037 During reset, IntReq=0, EPC=0, DOut = PRID_VAL if A1=15, else 0.
REQ-038 Reset asserted mid-exception (EXL=1) returns all state to reset values with no pending request retained.

Verification
REQ-039 Reset, then MTC0 SR=32'h0000_0401 and HWInt[0]=1 at PC=32'h3000, delayslot=0 -> IntReq=1 that cycle; next edge EPC=32'h3000, Cause=32'h0000_0400, SR.EXL=1, IntReq=0.
REQ-040 ExcCode=4, BadAddr=32'h1235, PC=32'h3008, delayslot=1, no interrupt -> EPC=32'h3004, BD=1, Cause.ExcCode=4, BadVAddr=32'h1235.
REQ-041 MTC0 Compare=10 and SR.TIE=1, IE=1 at Count=0 -> TI=1 after the edge where Count==10, then IntReq=1 with ExcCode 0; MTC0 Compare clears TI.
REQ-042 MTC0 Count=32'hFFFF_FFFE -> reads FFFFFFFF, then 0, then 1 on successive cycles.
REQ-043 We=1 (EPC <= 32'h4000) and ExcCode=10 in the same cycle at PC=32'h3010 -> EPC=32'h3010; then EXLClr -> EXL=0.
REQ-044 Assert reset asynchronously between edges while EXL=1 -> SR, Cause, EPC read 0 immediately; PRId reads 32'h18373580.
